// File: rtl/counter_cmd_pkg.sv
// Shared constants and state types for the stopwatch command core.
// The optional status readout is enabled by defining COUNTER_CMD_STATUS_EN.
package counter_cmd_pkg;

    localparam logic [7:0] CMD_RUN   = 8'h72;
    localparam logic [7:0] CMD_CLR   = 8'h63;
    localparam logic [7:0] CMD_MODE  = 8'h6D;
    localparam logic [7:0] CMD_STAT  = 8'h73;

    localparam logic [7:0] ASCII_OFS = 8'h30;
    localparam logic [7:0] CASE_OFS  = 8'h20;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

    typedef enum logic {
        STOP,
        RUN
    } ctrl_state_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GUARD,
        STATUS
    } tx_state_t;

endpackage

// File: rtl/counter_cmd_core_bcd.sv
// Multi-digit BCD up/down counter with per-digit carry/borrow and a
// one-cycle wrap pulse when the count rolls past either end of its range.
module bcd_updown_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step,
    input  logic                  dir,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                wrap_q, wrap_d;
    logic                chain;
    logic [3:0]          digit;

    // Next count: clear wins over a step; the ripple flag walks up the digits
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        chain   = 1'b1;
        digit   = 4'd0;
        if (clr) begin
            count_d = '0;
        end else if (step) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit = count_q[4*i +: 4];
                if (chain) begin
                    if (!dir) begin
                        if (digit == 4'd9) begin
                            count_d[4*i +: 4] = 4'd0;
                        end else begin
                            count_d[4*i +: 4] = digit + 4'd1;
                            chain = 1'b0;
                        end
                    end else begin
                        if (digit == 4'd0) begin
                            count_d[4*i +: 4] = 4'd9;
                        end else begin
                            count_d[4*i +: 4] = digit - 4'd1;
                            chain = 1'b0;
                        end
                    end
                end
            end
            wrap_d = chain;
        end
    end

    // Count and wrap registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_bcd = count_q;
    assign wrap      = wrap_q;

endmodule

// File: rtl/counter_cmd_core.sv
// Stopwatch control core: merges debounced buttons and UART command bytes,
// runs the BCD counter from a divided tick and echoes accepted commands.
// Defining COUNTER_CMD_STATUS_EN adds the 's' status readout over UART.
module counter_cmd_core #(
    parameter int         DIGITS   = 4,
    parameter int         TICK_DIV = 10_000_000,
    parameter logic [7:0] CMD_RUN  = 8'h72,
    parameter logic [7:0] CMD_CLR  = 8'h63,
    parameter logic [7:0] CMD_MODE = 8'h6D
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_run,
    input  logic                btn_clear,
    input  logic                btn_mode,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    input  logic                tx_busy,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic                run,
    output logic                mode,
    output logic [4*DIGITS-1:0] count_bcd,
    output logic                wrap
);

    import counter_cmd_pkg::*;

    localparam int             TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);

    logic cmd_run, cmd_clr, cmd_mode, ack_cmd;
    logic run_evt, clr_evt, mode_evt;
    logic tick;

    ctrl_state_t   state_q, state_d;
    logic          mode_q, mode_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;

    tx_state_t     tx_state_q, tx_state_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_byte_q, pend_byte_d;

    assign cmd_run  = rx_done && (rx_data == CMD_RUN);
    assign cmd_clr  = rx_done && (rx_data == CMD_CLR);
    assign cmd_mode = rx_done && (rx_data == CMD_MODE);
    assign ack_cmd  = cmd_run || cmd_clr || cmd_mode;

    assign run_evt  = btn_run   || cmd_run;
    assign clr_evt  = btn_clear || cmd_clr;
    assign mode_evt = btn_mode  || cmd_mode;

    assign tick = (state_q == RUN) && (tick_cnt_q == TICK_LAST);

`ifdef COUNTER_CMD_STATUS_EN
    localparam int SW = $clog2(DIGITS + 1);

    logic                cmd_stat;
    logic                stat_act_q, stat_act_d;
    logic [SW-1:0]       stat_idx_q, stat_idx_d;
    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic [3:0]          stat_digit;

    assign cmd_stat = rx_done && (rx_data == CMD_STAT);
`endif

    // Run/stop toggle, mode toggle and the tick divider
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q ^ mode_evt;
        tick_cnt_d = tick_cnt_q;
        if (run_evt) begin
            state_d = (state_q == RUN) ? STOP : RUN;
        end
        if (clr_evt) begin
            tick_cnt_d = '0;
        end else if (state_q == RUN) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        end
    end

    // Control and tick registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= STOP;
            mode_q     <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    bcd_updown_counter #(
        .DIGITS (DIGITS)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .step      (tick),
        .dir       (mode_q),
        .clr       (clr_evt),
        .count_bcd (count_bcd),
        .wrap      (wrap)
    );

    // Transmit sequencing: launch one byte, then wait for the UART busy cycle
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        pend_d      = pend_q;
        pend_byte_d = pend_byte_q;
`ifdef COUNTER_CMD_STATUS_EN
        stat_act_d  = stat_act_q;
        stat_idx_d  = stat_idx_q;
        snap_d      = snap_q;
        stat_digit  = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (stat_idx_q == SW'(DIGITS - 1 - i)) begin
                stat_digit = snap_q[4*i +: 4];
            end
        end
`endif
        case (tx_state_q)
            IDLE: begin
`ifdef COUNTER_CMD_STATUS_EN
                if (stat_act_q) begin
                    tx_state_d = STATUS;
                end else
`endif
                if (pend_q && !tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = pend_byte_q;
                    pend_d     = 1'b0;
                    tx_state_d = SEND;
                end
            end
            SEND: begin
                if (tx_busy) begin
                    tx_state_d = GUARD;
                end
            end
            GUARD: begin
                if (!tx_busy) begin
                    tx_state_d = IDLE;
                end
            end
            STATUS: begin
`ifdef COUNTER_CMD_STATUS_EN
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_state_d = SEND;
                    if (stat_idx_q == SW'(DIGITS)) begin
                        tx_data_d  = ASCII_LF;
                        stat_act_d = 1'b0;
                    end else begin
                        tx_data_d  = ASCII_OFS + {4'd0, stat_digit};
                        stat_idx_d = stat_idx_q + SW'(1);
                    end
                end
`else
                tx_state_d = IDLE;
`endif
            end
            default: tx_state_d = IDLE;
        endcase
        if (ack_cmd) begin
            pend_d      = 1'b1;
            pend_byte_d = rx_data - CASE_OFS;
        end
`ifdef COUNTER_CMD_STATUS_EN
        if (cmd_stat && !stat_act_q) begin
            stat_act_d = 1'b1;
            stat_idx_d = '0;
            snap_d     = count_bcd;
        end
`endif
    end

    // Transmit registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q  <= IDLE;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            pend_q      <= 1'b0;
            pend_byte_q <= 8'h00;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
        end
    end

`ifdef COUNTER_CMD_STATUS_EN
    // Status burst registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_act_q <= 1'b0;
            stat_idx_q <= '0;
            snap_q     <= '0;
        end else begin
            stat_act_q <= stat_act_d;
            stat_idx_q <= stat_idx_d;
            snap_q     <= snap_d;
        end
    end
`endif

    assign run      = (state_q == RUN);
    assign mode     = mode_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_counter_cmd_core.sv
// Self-checking bench for counter_cmd_core (DIGITS=2, TICK_DIV=4) using a
// decimal reference model of the stopwatch and a simple UART emulator.
module tb_counter_cmd_core;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int MOD      = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_run = 1'b0, btn_clear = 1'b0, btn_mode = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       hold_busy = 1'b0, uart_busy = 1'b0;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       run, mode, wrap;
    logic [7:0] count_bcd;

    assign tx_busy = uart_busy | hold_busy;

    int checks = 0;
    int failures = 0;

    int m_count = 0;
    int m_phase = 0;
    bit m_run = 0, m_mode = 0, m_wrap = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    counter_cmd_core #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_run   (btn_run),
        .btn_clear (btn_clear),
        .btn_mode  (btn_mode),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .run       (run),
        .mode      (mode),
        .count_bcd (count_bcd),
        .wrap      (wrap)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // UART transmitter stand-in: records each started byte and stays busy a while
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                obs_q.push_back(tx_data);
                uart_busy = 1'b1;
                repeat (3) @(negedge clk);
                uart_busy = 1'b0;
            end
        end
    end

    // Global time limit so the run always terminates
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] to_bcd(int v);
        logic [3:0] tens, ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic resetModel();
        m_count = 0;
        m_phase = 0;
        m_run   = 0;
        m_mode  = 0;
        m_wrap  = 0;
    endtask

    // One clock cycle of stimulus, reference-model update and output check
    task automatic applyStimulus(bit br, bit bc, bit bm, bit rv, logic [7:0] rd);
        bit c_run, c_clr, c_mode, tick;
        int prev;
        btn_run   = br;
        btn_clear = bc;
        btn_mode  = bm;
        rx_done   = rv;
        rx_data   = rd;
        @(posedge clk);
        #1;
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        btn_mode  = 1'b0;
        rx_done   = 1'b0;

        c_run  = rv && (rd == 8'h72);
        c_clr  = rv && (rd == 8'h63);
        c_mode = rv && (rd == 8'h6D);
        prev   = m_count;
        tick   = m_run && (m_phase == TICK_DIV - 1);
        m_wrap = 0;
        if (bc || c_clr) begin
            m_count = 0;
            m_phase = 0;
        end else if (tick) begin
            m_phase = 0;
            if (!m_mode) begin
                m_wrap  = (m_count == MOD - 1);
                m_count = (m_count + 1) % MOD;
            end else begin
                m_wrap  = (m_count == 0);
                m_count = (m_count + MOD - 1) % MOD;
            end
        end else if (m_run) begin
            m_phase++;
        end
        if (br || c_run)  m_run  = !m_run;
        if (bm || c_mode) m_mode = !m_mode;
        if (c_run || c_clr || c_mode) exp_q.push_back(rd - 8'h20);
`ifdef COUNTER_CMD_STATUS_EN
        if (rv && rd == 8'h73) begin
            exp_q.push_back(8'h30 + 8'(prev / 10));
            exp_q.push_back(8'h30 + 8'(prev % 10));
            exp_q.push_back(8'h0A);
        end
`endif
        checkOutput("count", count_bcd, to_bcd(m_count));
        checkOutput("run", run, m_run);
        checkOutput("mode", mode, m_mode);
        checkOutput("wrap", wrap, m_wrap);
    endtask

    task automatic idle(int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 8'h00);
    endtask

    task automatic compareTx(string tag);
        checkOutput({tag, "_len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checkOutput({tag, "_byte"}, obs_q[i], exp_q[i]);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Directed scenarios followed by a randomised burst
    initial begin
        bit found;
        int gap;
        bit br, bc, bm, rv;
        logic [7:0] rd;
        logic [7:0] cmd_tab [5];
        cmd_tab = '{8'h72, 8'h63, 8'h6D, 8'h7A, 8'h41};

        $display("[TB] start");
        #3;
        checkOutput("rst_count", count_bcd, 8'h00);
        checkOutput("rst_run", run, 1'b0);
        checkOutput("rst_mode", mode, 1'b0);
        checkOutput("rst_wrap", wrap, 1'b0);
        checkOutput("rst_tx_start", tx_start, 1'b0);
        checkOutput("rst_tx_data", tx_data, 8'h00);
        resetModel();
        @(negedge clk);
        rst = 1'b1;
        idle(5);

        // Count to 37 then pull reset asynchronously mid-cycle
        applyStimulus(1, 0, 0, 0, 8'h00);
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            idle(1);
            if (m_count == 37) found = 1;
        end
        checkOutput("reach_37", found, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_count", count_bcd, 8'h00);
        checkOutput("async_rst_run", run, 1'b0);
        checkOutput("async_rst_mode", mode, 1'b0);
        checkOutput("async_rst_wrap", wrap, 1'b0);
        checkOutput("async_rst_tx_start", tx_start, 1'b0);
        resetModel();
        @(negedge clk);
        rst = 1'b1;
        idle(10);

        // Count up through 99 and wrap to 00
        applyStimulus(1, 0, 0, 0, 8'h00);
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            idle(1);
            if (m_count == 99) found = 1;
        end
        checkOutput("reach_99", found, 1'b1);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            idle(1);
            if (m_wrap) found = 1;
        end
        checkOutput("up_wrap_seen", found, 1'b1);
        checkOutput("up_wrap_count", count_bcd, 8'h00);
        checkOutput("up_wrap_pulse", wrap, 1'b1);
        idle(2);

        // Stop, clear, select down, then start from UART
        applyStimulus(1, 0, 0, 0, 8'h00);
        applyStimulus(0, 1, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 0, 8'h00);
        idle(3);
        obs_q.delete();
        exp_q.delete();
        applyStimulus(0, 0, 0, 1, 8'h72);
        checkOutput("uart_run", run, 1'b1);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            idle(1);
            if (m_wrap) found = 1;
        end
        checkOutput("down_wrap_seen", found, 1'b1);
        checkOutput("down_wrap_count", count_bcd, 8'h99);
        checkOutput("down_wrap_pulse", wrap, 1'b1);
        idle(20);
        compareTx("ack_R");

        // Clear collides with a tick at 45
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            idle(1);
            if (m_count == 45 && m_phase == TICK_DIV - 1) found = 1;
        end
        checkOutput("reach_45", found, 1'b1);
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("clr_tick_count", count_bcd, 8'h00);
        checkOutput("clr_tick_wrap", wrap, 1'b0);
        checkOutput("clr_tick_run", run, 1'b1);
        idle(3);

        // Commands while the transmitter is held busy: only the latest is echoed
        hold_busy = 1'b1;
        obs_q.delete();
        exp_q.delete();
        applyStimulus(0, 0, 0, 1, 8'h6D);
        idle(2);
        applyStimulus(0, 0, 0, 1, 8'h63);
        idle(2);
        applyStimulus(0, 0, 0, 1, 8'h7A);
        idle(5);
        checkOutput("held_no_tx", obs_q.size(), 0);
        hold_busy = 1'b0;
        idle(20);
        exp_q.delete();
        exp_q.push_back(8'h43);
        compareTx("ack_latest");
        checkOutput("tx_data_hold", tx_data, 8'h43);

        // Button and UART run in the same cycle toggle once
        applyStimulus(1, 0, 0, 1, 8'h72);
        idle(20);
        compareTx("ack_dual");

        // Randomised buttons and spaced UART bytes
        gap = 100;
        for (int i = 0; i < 400; i++) begin
            br = ($urandom_range(0, 19) == 0);
            bc = ($urandom_range(0, 29) == 0);
            bm = ($urandom_range(0, 24) == 0);
            rv = 1'b0;
            rd = 8'h00;
            if (gap >= 15 && $urandom_range(0, 4) == 0) begin
                rv  = 1'b1;
                rd  = cmd_tab[$urandom_range(0, 4)];
                gap = 0;
            end else begin
                gap++;
            end
            applyStimulus(br, bc, bm, rv, rd);
        end
        idle(20);
        compareTx("ack_rand");

        // Status request
        if (m_run) applyStimulus(1, 0, 0, 0, 8'h00);
        if (m_mode) applyStimulus(0, 0, 1, 0, 8'h00);
        applyStimulus(0, 1, 0, 0, 8'h00);
        applyStimulus(1, 0, 0, 0, 8'h00);
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            idle(1);
            if (m_count == 27) found = 1;
        end
        checkOutput("reach_27", found, 1'b1);
        applyStimulus(1, 0, 0, 0, 8'h00);
        idle(2);
        obs_q.delete();
        exp_q.delete();
        applyStimulus(0, 0, 0, 1, 8'h73);
        idle(40);
        compareTx("status");
        checkOutput("status_count", count_bcd, 8'h27);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
